// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Handshake bundle for the pipelined logic unit.
//   Input channel : in_valid, in_ready, op[3:0], a[WIDTH], b[WIDTH], acc_sel
//   Output channel: out_valid, out_ready, result[WIDTH], zero, parity,
//                   illegal, ops_done[CNT_W]
// Modports:
//   master - the operand decode / result consumer side (drives operands and
//            out_ready, observes results)
//   slave  - the logic unit itself
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic             illegal;
    logic [CNT_W-1:0] ops_done;

    modport master (
        output in_valid, op, a, b, acc_sel, out_ready,
        input  in_ready, out_valid, result, zero, parity, illegal, ops_done
    );

    modport slave (
        input  in_valid, op, a, b, acc_sel, out_ready,
        output in_ready, out_valid, result, zero, parity, illegal, ops_done
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage pipelined bitwise logic unit with valid/ready handshakes.
//   Stage 1 captures op/a/b/acc_sel; stage 2 computes and registers the result
//   together with zero, parity and illegal flags. acc_sel substitutes the
//   previous result for operand A, so accumulate chains run back-to-back.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - logic_unit_pipe_if.slave (operand channel, result channel,
//           ops_done counter of completed handoffs)
// Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a.
// Optional build macro LOGIC_UNIT_REDUCE_EN: ops 8..11 become reductions of
// the effective A (&, |, ^, ~^) zero-extended to WIDTH. All other opcodes are
// illegal: result 0, illegal=1.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_pipe_if.slave  bus
);

    // Returns {illegal, result} for one operation.
    function automatic logic [WIDTH:0] compute_op(
        input logic [3:0]       op_i,
        input logic [WIDTH-1:0] ea_i,
        input logic [WIDTH-1:0] eb_i
    );
        logic [WIDTH-1:0] res;
        logic             ill;
        res = {WIDTH{1'b0}};
        ill = 1'b0;
        case (op_i)
            4'd0: res = ea_i & eb_i;
            4'd1: res = ~(ea_i & eb_i);
            4'd2: res = ea_i | eb_i;
            4'd3: res = ~(ea_i | eb_i);
            4'd4: res = ea_i ^ eb_i;
            4'd5: res = ~(ea_i ^ eb_i);
            4'd6: res = ~ea_i;
            4'd7: res = ea_i;
`ifdef LOGIC_UNIT_REDUCE_EN
            4'd8:  res = {{(WIDTH-1){1'b0}}, &ea_i};
            4'd9:  res = {{(WIDTH-1){1'b0}}, |ea_i};
            4'd10: res = {{(WIDTH-1){1'b0}}, ^ea_i};
            4'd11: res = {{(WIDTH-1){1'b0}}, ~^ea_i};
`endif
            default: begin
                res = {WIDTH{1'b0}};
                ill = 1'b1;
            end
        endcase
        return {ill, res};
    endfunction

    // Even-parity bit of a result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] v_i);
        return ^v_i;
    endfunction

    // Stage 1 registers
    logic             s1_valid_r;
    logic [3:0]       s1_op_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_acc_r;

    // Stage 2 / output registers
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             parity_r;
    logic             illegal_r;
    logic [WIDTH-1:0] last_result_r;
    logic [CNT_W-1:0] ops_done_r;

    // Handshake and datapath combinational signals
    logic             advance_s;
    logic             in_ready_s;
    logic             capture_s;
    logic             handoff_s;
    logic [WIDTH-1:0] eff_a_s;
    logic [WIDTH:0]   comp_s;

    // Pipeline flow control; stage 1 may refill in the same cycle it advances.
    always_comb begin
        advance_s  = s1_valid_r & (~out_valid_r | bus.out_ready);
        in_ready_s = ~s1_valid_r | ~out_valid_r | bus.out_ready;
        capture_s  = bus.in_valid & in_ready_s;
        handoff_s  = out_valid_r & bus.out_ready;
    end

    // Effective operand A and the stage-2 computation.
    always_comb begin
        if (s1_acc_r) begin
            eff_a_s = last_result_r;
        end else begin
            eff_a_s = s1_a_r;
        end
        comp_s = compute_op(s1_op_r, eff_a_s, s1_b_r);
    end

    // Stage 1 capture of operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 4'd0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_acc_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                s1_valid_r <= 1'b1;
                s1_op_r    <= bus.op;
                s1_a_r     <= bus.a;
                s1_b_r     <= bus.b;
                s1_acc_r   <= bus.acc_sel;
            end else if (advance_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // Stage 2 result registers; last_result moves with the op so chaining needs no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            result_r      <= {WIDTH{1'b0}};
            zero_r        <= 1'b1;
            parity_r      <= 1'b0;
            illegal_r     <= 1'b0;
            last_result_r <= {WIDTH{1'b0}};
        end else begin
            if (advance_s) begin
                out_valid_r   <= 1'b1;
                result_r      <= comp_s[WIDTH-1:0];
                zero_r        <= (comp_s[WIDTH-1:0] == {WIDTH{1'b0}});
                parity_r      <= parity_of(comp_s[WIDTH-1:0]);
                illegal_r     <= comp_s[WIDTH];
                last_result_r <= comp_s[WIDTH-1:0];
            end else if (handoff_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Completed-handoff counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_r <= {CNT_W{1'b0}};
        end else begin
            if (handoff_s) begin
                ops_done_r <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.parity    = parity_r;
    assign bus.illegal   = illegal_r;
    assign bus.ops_done  = ops_done_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Scoreboard bench: the driver pushes the expected response of every accepted
// operation into a queue; an independent monitor pops and compares whenever a
// result is handed off. CNT_W is 4 so the counter wraps during the run.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             parity;
        logic             illegal;
    } exp_t;

    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_last;
    int               model_cnt;
    int               ready_mode;   // 0 hold low, 1 high, 2 random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model computed from the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        e.illegal = 1'b0;
        case (op)
            4'd0: e.result = a & b;
            4'd1: e.result = ~(a & b);
            4'd2: e.result = a | b;
            4'd3: e.result = ~(a | b);
            4'd4: e.result = a ^ b;
            4'd5: e.result = ~(a ^ b);
            4'd6: e.result = ~a;
            4'd7: e.result = a;
`ifdef LOGIC_UNIT_REDUCE_EN
            4'd8:  e.result = (a == {WIDTH{1'b1}}) ? 16'd1 : 16'd0;
            4'd9:  e.result = (a != 16'd0) ? 16'd1 : 16'd0;
            4'd10: e.result = WIDTH'($countones(a) % 2);
            4'd11: e.result = WIDTH'(1 - ($countones(a) % 2));
`endif
            default: begin
                e.result  = 16'd0;
                e.illegal = 1'b1;
            end
        endcase
        e.zero   = (e.result == 16'd0);
        e.parity = ($countones(e.result) % 2) == 1;
        return e;
    endfunction

    // Out_ready driver; the only writer of out_ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b0;
            1: bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: compares each handed-off result and checks output hold while stalled.
    logic             held_v;
    logic [WIDTH-1:0] held_res;
    logic [2:0]       held_flags;
    always @(negedge clk) begin
        if (!rst_n) begin
            model_cnt = 0;
            held_v    = 1'b0;
        end else begin
            if (held_v && bus.out_valid) begin
                check("hold_result", 32'(bus.result), 32'(held_res));
                check("hold_flags", 32'({bus.zero, bus.parity, bus.illegal}), 32'(held_flags));
            end
            held_v = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.result), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 32'(bus.result), 32'(e.result));
                    check("zero", 32'(bus.zero), 32'(e.zero));
                    check("parity", 32'(bus.parity), 32'(e.parity));
                    check("illegal", 32'(bus.illegal), 32'(e.illegal));
                end
                check("ops_done", 32'(bus.ops_done), 32'(model_cnt % (1 << CNT_W)));
                model_cnt++;
            end else if (bus.out_valid) begin
                held_v     = 1'b1;
                held_res   = bus.result;
                held_flags = {bus.zero, bus.parity, bus.illegal};
            end
        end
    end

    // Drive one op; caller is at posedge+1. Returns at posedge+1 after acceptance.
    task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic acc);
        logic ok;
        exp_t e;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc_sel  = acc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(op, acc ? model_last : a, b);
            model_last = e.result;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        ready_mode   = 0;
        model_last   = 16'd0;
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = 16'd0;
        bus.b        = 16'd0;
        bus.acc_sel  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        check("rst_parity", 32'(bus.parity), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_ops_done", 32'(bus.ops_done), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Reset mid-stream with two ops in flight.
        @(posedge clk); #1;
        send(4'd4, 16'h1234, 16'h00FF, 1'b0);
        send(4'd2, 16'h0F0F, 16'hF000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ops_done", 32'(bus.ops_done), 32'd0);
        check("midrst_zero", 32'(bus.zero), 32'd1);
        exp_q.delete();
        model_last = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk); #1;
        send(4'd2, 16'h00F0, 16'h0F00, 1'b0);
        @(negedge clk);
        check("latency_n1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("latency_n2", 32'(bus.out_valid), 32'd1);
        check("latency_result", 32'(bus.result), 32'h0FF0);
        @(posedge clk); #1;

        // Opcode sweep.
        for (int k = 0; k < 8; k++) begin
            send(4'(k), 16'hA5A5, 16'h0FF0, 1'b0);
        end

        // Accumulate chaining, back-to-back.
        send(4'd4, 16'h00FF, 16'h0F0F, 1'b0);
        send(4'd4, 16'hFFFF, 16'h0FF0, 1'b1);

        // Reduction / illegal opcodes.
        send(4'd9, 16'h0100, 16'h0000, 1'b0);
        send(4'd13, 16'h0100, 16'h0000, 1'b0);
        send(4'd15, 16'hFFFF, 16'hFFFF, 1'b0);

        // Backpressure: four ops while the consumer stalls.
        repeat (4) @(posedge clk);
        #1;
        ready_mode = 0;
        @(posedge clk); #1;
        fork
            begin
                send(4'd0, 16'h1111, 16'h3333, 1'b0);
                send(4'd2, 16'h2222, 16'h4444, 1'b0);
                send(4'd4, 16'h3333, 16'h5555, 1'b1);
                send(4'd7, 16'h4444, 16'h6666, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_result", 32'(bus.result), 32'h1111);
                repeat (2) @(negedge clk);
                check("bp_in_ready_late", 32'(bus.in_ready), 32'd0);
                ready_mode = 1;
            end
        join

        // Randomised traffic with random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 200; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            send(rop, 16'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Drain.
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("final_ops_done", 32'(bus.ops_done), 32'(model_cnt % (1 << CNT_W)));
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
